rr_pkt_arbiter: RTL and testbench
=================================

Name: rr_pkt_arbiter

Overview:
- Round-robin packet arbiter that shares one downstream stream port between N upstream requesters.
- Grant is held for a whole packet (until a beat with last=1), then passes to the next requester in rotating order.
- Payload type is a type parameter, so one RTL source serves every instantiated payload width or struct.
- Sits in front of any shared sink (bus master, FIFO write port, serializer).

Parameters:
- N, 4, number of requesters; legal range 1..16.
- T, type bit [7:0], payload type carried per beat (type parameter).
- IW, (N > 1) ? $clog2(N) : 1, width of grant index; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N  per-requester beat valid.
- req_last  input  N  per-requester last-beat-of-packet flag.
- req_data  input  N x T  per-requester payload (unpacked array of T).
- req_ready  output  N  per-requester ready.
- out_valid  output  1  downstream beat valid.
- out_last  output  1  downstream last flag.
- out_data  output  T  downstream payload.
- out_ready  input  1  downstream ready.
- out_idx  output  IW  index of the currently granted requester.

Behaviour:
- State machine: IDLE and BUSY; state register plus grant register g (IW bits) plus round-robin pointer p (IW bits).
- Reset (async, rst_n=0) clears the block immediately:
  - state=IDLE, g=0, p=0.
  - All req_ready=0, out_valid=0, out_last=0, out_data=all-zero, out_idx=0.
- Reset asserted mid-packet: the packet is abandoned. After release, arbitration restarts from p=0. No beat is replayed.
- IDLE:
  - out_valid=0 and all req_ready=0.
  - If any req_valid bit is set, g becomes the first index i with req_valid[i]=1, searching p, p+1, ..., N-1, 0, ..., p-1 (modulo N). State moves to BUSY on the next edge.
  - If no req_valid bit is set, the block stays in IDLE.
  - Result: one bubble cycle per packet; the first beat leaves 1 cycle after req_valid is seen, at the earliest.
- BUSY, combinational pass-through from requester g:
  - out_valid=req_valid[g], out_last=req_last[g], out_data=req_data[g].
  - req_ready[g]=out_ready; req_ready of every other requester = 0.
  - out_idx=g, held stable for the whole packet.
- Beat handshake = out_valid & out_ready.
  - On a handshake with out_last=1: state goes to IDLE and p becomes (g+1) mod N. p wraps from N-1 to 0.
  - A handshake with out_last=0 stays in BUSY.
  - If req_valid[g] drops mid-packet, the block stays in BUSY with out_valid=0. The grant is not revoked; there is no timeout.
- Single-beat packets (last=1 on the first beat) take exactly 2 cycles per packet under a continuous request.
- Requesters must hold data and last stable while valid=1 and ready=0; the arbiter does not check this.
- N=1: p and g are always 0. The IDLE bubble still applies.
- Fairness: each requester with continuous requests waits at most N-1 packets.
- out_data when out_valid=0 is don't-care, except it must be zero during reset.

Optional Feature:
- Macro RR_PKT_ARBITER_GNT_CNT_EN.
- When defined, adds output gnt_cnt (N x 16, unpacked array).
  - gnt_cnt[i] increments by 1 on each completed packet (last-beat handshake) from requester i.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_n.
- When undefined, the port and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 with req_valid=4'b1111 -> all outputs 0, out_idx=0. Release with only req_valid[2]=1 -> BUSY next cycle, out_idx=2.
- Rotation: all four requesters continuously send single-beat packets, out_ready=1 -> grant order 0,1,2,3,0,..., one beat every 2 cycles.
- Packet hold: req0 sends 3 beats (last on beat 3) while req1 is valid throughout -> out_idx=0 for all 3 beats, req_ready[1]=0 throughout; req1 granted after 1 bubble cycle.
- Backpressure: out_ready=0 for 5 cycles mid-packet -> out_data stable, no pointer change; resumes when out_ready=1.
- Wrap and skip: p=3 with req_valid=4'b0010 -> grant 1.
- Mid-packet reset: rst_n pulsed low during beat 2 of a packet -> outputs 0 immediately, p=0 after release. With RR_PKT_ARBITER_GNT_CNT_EN defined, all gnt_cnt=0.

Source files
------------

// File: rtl/rr_pkt_arbiter.sv
// rr_pkt_arbiter: round-robin packet arbiter sharing one downstream stream
// port between N upstream requesters. A grant is held from the first beat of
// a packet until its last-beat handshake, then the rotating pointer moves to
// the requester after the one just served.
//
// Optional feature: define RR_PKT_ARBITER_GNT_CNT_EN to add per-requester
// saturating 16-bit counters of completed packets (output gnt_cnt).
module rr_pkt_arbiter #(
    parameter int  N  = 4,
    parameter type T  = bit [7:0],
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_valid,
    input  logic [N-1:0]  req_last,
    input  T              req_data [N],
    output logic [N-1:0]  req_ready,
    output logic          out_valid,
    output logic          out_last,
    output T              out_data,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx
`ifdef RR_PKT_ARBITER_GNT_CNT_EN
    ,
    output logic [15:0]   gnt_cnt [N]
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] g;
    logic [IW-1:0] p;

    logic          any_req;
    logic [IW-1:0] pick;
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic [IW-1:0] g_inc;
    logic          fire_last;

    // Rotating search starting at p: first valid requester among p, p+1, ... modulo N.
    always_comb begin
        any_req = 1'b0;
        pick    = p;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, p} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (!any_req && req_valid[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    // Pointer to the requester following the current grant, wrapping N-1 to 0.
    always_comb begin
        g_inc = g + IW'(1);
        if (g == IW'(N - 1)) begin
            g_inc = '0;
        end
    end

    // Pass the granted requester straight through while BUSY; everything is quiet in IDLE,
    // which also forces all outputs to zero while reset holds the state at IDLE.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        req_ready = '0;
        if (state == BUSY) begin
            out_valid    = req_valid[g];
            out_last     = req_last[g];
            out_data     = req_data[g];
            req_ready[g] = out_ready;
        end
    end

    assign fire_last = out_valid & out_ready & out_last;
    assign out_idx   = g;

    // Arbitration state machine: pick a grant in IDLE, hold it until the last-beat handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            g     <= '0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        g     <= pick;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (fire_last) begin
                        p     <= g_inc;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RR_PKT_ARBITER_GNT_CNT_EN
    // Count completed packets per requester, saturating at the top of the 16-bit range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                gnt_cnt[i] <= '0;
            end
        end else if (fire_last && (gnt_cnt[g] != 16'hFFFF)) begin
            gnt_cnt[g] <= gnt_cnt[g] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// tb_rr_pkt_arbiter: directed bench for rr_pkt_arbiter (N=4, 8-bit payload).
// Per-requester driver queues feed the DUT; applyStimulus pushes each beat
// into the expected queue in the hand-computed grant order, and a monitor
// pops and compares on every downstream handshake.
module tb_rr_pkt_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_last  = '0;
    bit   [7:0]   req_data [N];
    logic [N-1:0] req_ready;
    logic         out_valid;
    logic         out_last;
    bit   [7:0]   out_data;
    logic         out_ready;
    logic [1:0]   out_idx;
`ifdef RR_PKT_ARBITER_GNT_CNT_EN
    logic [15:0]  gnt_cnt [N];
`endif

    rr_pkt_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_idx   (out_idx)
`ifdef RR_PKT_ARBITER_GNT_CNT_EN
        ,
        .gnt_cnt   (gnt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic       last;
        logic [7:0] data;
    } beat_t;

    beat_t        exp_q [$];
    logic [8:0]   drv_q [N][$];
    int           hs_cyc [$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] fire;
    beat_t        mon_exp;

    // Free-running cycle count used to timestamp handshakes.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Each requester presents the head of its queue; a beat leaves the queue after it was accepted.
    always begin
        @(negedge clk);
        fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i] && drv_q[i].size() > 0) begin
                void'(drv_q[i].pop_front());
            end
            if (drv_q[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_last[i]  = drv_q[i][0][8];
                req_data[i]  = drv_q[i][0][7:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[i]  = '0;
            end
        end
    end

    // Scoreboard monitor: every downstream handshake must match the next expected beat.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            hs_cyc.push_back(cyc);
            checkOutput("req_ready_onehot", 32'(req_ready), 32'(4'(1) << out_idx));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat: got idx %0d data %0h last %0b, expected none",
                         out_idx, out_data, out_last);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("beat", 32'({out_idx, out_last, out_data}), 32'(mon_exp));
            end
        end
    end

    task automatic applyStimulus(input int req, input int nbeats, input logic [7:0] base);
        logic       last;
        logic [7:0] d;
        for (int k = 0; k < nbeats; k++) begin
            last = (k == nbeats - 1);
            d    = 8'(base + 8'(k));
            drv_q[req].push_back({last, d});
            exp_q.push_back(beat_t'({2'(req), last, d}));
        end
    endtask

    task automatic flushAll();
        for (int i = 0; i < N; i++) drv_q[i].delete();
        exp_q.delete();
        hs_cyc.delete();
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        checkOutput({tag, "_out_last"},  32'(out_last),  32'(0));
        checkOutput({tag, "_out_data"},  32'(out_data),  32'(0));
        checkOutput({tag, "_out_idx"},   32'(out_idx),   32'(0));
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        flushAll();
        #1;
        checkQuiet("rst");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput({name, "_drained"}, 32'(exp_q.size()), 32'(0));
        if (exp_q.size() != 0) flushAll();
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic waitHandshakes(input string name, input int count, input int budget);
        int n;
        n = 0;
        while (hs_cyc.size() < count && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput({name, "_hs_seen"}, 32'(hs_cyc.size() >= count), 32'(1));
    endtask

    // Bound the whole run so a stuck design still reports.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;

        // Reset with every requester valid: everything stays quiet.
        for (int i = 0; i < N; i++) drv_q[i].push_back({1'b1, 8'(8'h10 + 8'(i))});
        repeat (3) @(negedge clk);
        checkQuiet("reset_all_valid");

        // Release with only requester 2 valid.
        @(posedge clk);
        #2;
        drv_q[0].delete();
        drv_q[1].delete();
        drv_q[3].delete();
        exp_q.push_back(beat_t'({2'd2, 1'b1, 8'h12}));
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_bubble_out_valid", 32'(out_valid), 32'(0));
        @(negedge clk);
        checkOutput("busy_out_idx",    32'(out_idx),   32'(2));
        checkOutput("busy_out_valid",  32'(out_valid), 32'(1));
        checkOutput("busy_out_data",   32'(out_data),  32'(8'h12));
        checkOutput("busy_req_ready",  32'(req_ready), 32'(0));
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        waitDrain("first_grant", 20);

        // Rotation: single-beat packets from all four, grant order 0,1,2,3,0,1,2,3.
        doReset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) applyStimulus(i, 1, 8'(8'h20 + 8'(8 * r + i)));
        waitDrain("rotation", 100);
        checkOutput("rotation_beats", 32'(hs_cyc.size()), 32'(8));
        for (int k = 0; k + 1 < hs_cyc.size(); k++)
            checkOutput("rotation_spacing", 32'(hs_cyc[k+1] - hs_cyc[k]), 32'(2));
`ifdef RR_PKT_ARBITER_GNT_CNT_EN
        for (int i = 0; i < N; i++) checkOutput("gnt_cnt_rotation", 32'(gnt_cnt[i]), 32'(2));
`endif

        // Packet hold: req0 sends 3 beats while req1 waits, then req1 after one bubble.
        doReset();
        applyStimulus(0, 3, 8'h40);
        applyStimulus(1, 1, 8'h50);
        waitDrain("hold", 60);
        checkOutput("hold_beats", 32'(hs_cyc.size()), 32'(4));
        if (hs_cyc.size() == 4) begin
            checkOutput("hold_gap_b1_b2",  32'(hs_cyc[1] - hs_cyc[0]), 32'(1));
            checkOutput("hold_gap_b2_b3",  32'(hs_cyc[2] - hs_cyc[1]), 32'(1));
            checkOutput("hold_gap_bubble", 32'(hs_cyc[3] - hs_cyc[2]), 32'(2));
        end

        // Backpressure: stall 5 cycles on beat 2 of a req2 packet.
        doReset();
        applyStimulus(2, 3, 8'h60);
        waitHandshakes("bp_first", 1, 40);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_out_data",  32'(out_data),  32'(8'h61));
            checkOutput("bp_out_idx",   32'(out_idx),   32'(2));
            checkOutput("bp_out_valid", 32'(out_valid), 32'(1));
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        waitDrain("backpressure", 40);

        // Wrap and skip: pointer is now 3, only req1 valid -> grant 1.
        applyStimulus(1, 1, 8'h70);
        waitDrain("wrap_skip", 20);
        // Pointer is now 2: req3 wins over req1.
        applyStimulus(3, 1, 8'h80);
        applyStimulus(1, 1, 8'h90);
        waitDrain("wrap_order", 30);

        // Mid-packet reset: move pointer to 2, abandon a req2 packet on beat 2.
        doReset();
        applyStimulus(1, 1, 8'hA0);
        waitDrain("pre_reset", 20);
        hs_cyc.delete();
        applyStimulus(2, 3, 8'hB0);
        waitHandshakes("mid_first", 1, 40);
        checkOutput("mid_beat2_valid", 32'(out_valid), 32'(1));
        checkOutput("mid_beat2_data",  32'(out_data),  32'(8'hB1));
        rst_n = 1'b0;
        #1;
        checkQuiet("mid_reset");
`ifdef RR_PKT_ARBITER_GNT_CNT_EN
        for (int i = 0; i < N; i++) checkOutput("gnt_cnt_reset", 32'(gnt_cnt[i]), 32'(0));
`endif
        flushAll();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        // Pointer restarts at 0: req0 before req3.
        applyStimulus(0, 1, 8'hC0);
        applyStimulus(3, 1, 8'hD0);
        waitDrain("post_reset", 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
